// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer: key strobes -> shift-register pulses, operand loads, ALU req/done handshake.
// Responses 1 cycle after key accept (delete 2); key_ready low 2 cycles after each key and for all of CALC.
module calc_entry_ctrl #(
  parameter int MAX_DIGITS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  output logic [7:0] sr_data,
  output logic       sr_shren,
  output logic       sr_del,
  output logic [3:0] dig_cnt,
  output logic       a_load,
  output logic       a_from_res,
  output logic       b_load,
  output logic [1:0] op,
  output logic       alu_req,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       result_show,
  output logic       err
);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, CALC, RESULT, ERROR} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t     state, state_nx;
  logic [1:0] gap, gap_nx;
  logic       del_pend, del_pend_nx;
  logic [7:0] sr_data_nx;
  logic       sr_shren_nx, sr_del_nx, a_load_nx, a_from_res_nx, b_load_nx;
  logic [3:0] dig_cnt_nx;
  logic [1:0] op_nx;
  logic       alu_req_nx, result_show_nx, err_nx;

  logic       acc, is_dig, is_op, is_eq, is_clr, dig_full;
  logic [1:0] op_code;

  assign key_ready = (gap == 2'd0) && (state != CALC);
  assign acc       = key_valid && key_ready;
  assign is_dig    = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign is_eq     = (key_code == 8'h3D);
  assign is_clr    = (key_code == 8'h43);
  assign dig_full  = (dig_cnt == MAX_CNT);

  always_comb begin
    is_op   = 1'b1;
    op_code = 2'b00;
    case (key_code)
      8'h2B:   op_code = 2'b00;
      8'h2D:   op_code = 2'b01;
      8'h2A:   op_code = 2'b10;
      8'h2F:   op_code = 2'b11;
      default: is_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nx       = state;
    gap_nx         = (gap != 2'd0) ? gap - 2'd1 : 2'd0;
    del_pend_nx    = 1'b0;
    sr_data_nx     = sr_data;
    sr_shren_nx    = 1'b0;
    sr_del_nx      = del_pend;
    dig_cnt_nx     = dig_cnt;
    a_load_nx      = 1'b0;
    a_from_res_nx  = 1'b0;
    b_load_nx      = 1'b0;
    op_nx          = op;
    alu_req_nx     = alu_req;
    result_show_nx = result_show;
    err_nx         = err;

    if (acc) begin
      gap_nx = 2'd2;
      // Clear is legal from every state that can accept a key.
      if (is_clr) begin
        sr_del_nx      = 1'b1;
        dig_cnt_nx     = 4'd0;
        op_nx          = 2'b00;
        err_nx         = 1'b0;
        result_show_nx = 1'b0;
        state_nx       = ENTER_A;
      end else begin
        case (state)
          ENTER_A, ENTER_B: begin
            if (is_dig) begin
              if (!dig_full) begin
                sr_data_nx  = key_code;
                sr_shren_nx = 1'b1;
                dig_cnt_nx  = dig_cnt + 4'd1;
              end
            end else if (is_op) begin
              if (state == ENTER_A && dig_cnt != 4'd0) begin
                op_nx       = op_code;
                a_load_nx   = 1'b1;
                del_pend_nx = 1'b1;
                dig_cnt_nx  = 4'd0;
                state_nx    = ENTER_B;
              end else if (state == ENTER_B && dig_cnt == 4'd0) begin
                op_nx = op_code;
              end
            end else if (is_eq && state == ENTER_B && dig_cnt != 4'd0) begin
              b_load_nx   = 1'b1;
              del_pend_nx = 1'b1;
              dig_cnt_nx  = 4'd0;
              alu_req_nx  = 1'b1;
              state_nx    = CALC;
            end
          end
          RESULT: begin
            if (is_dig) begin
              sr_data_nx     = key_code;
              sr_shren_nx    = 1'b1;
              dig_cnt_nx     = 4'd1;
              result_show_nx = 1'b0;
              state_nx       = ENTER_A;
            end else if (is_op) begin
              a_from_res_nx  = 1'b1;
              op_nx          = op_code;
              result_show_nx = 1'b0;
              state_nx       = ENTER_B;
            end
          end
          default: ;
        endcase
      end
    end

    // Error takes priority over a simultaneous done.
    if (state == CALC) begin
      if (alu_err) begin
        alu_req_nx = 1'b0;
        err_nx     = 1'b1;
        state_nx   = ERROR;
      end else if (alu_done) begin
        alu_req_nx     = 1'b0;
        result_show_nx = 1'b1;
        state_nx       = RESULT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ENTER_A;
      gap         <= 2'd0;
      del_pend    <= 1'b0;
      sr_data     <= 8'h00;
      sr_shren    <= 1'b0;
      sr_del      <= 1'b0;
      dig_cnt     <= 4'd0;
      a_load      <= 1'b0;
      a_from_res  <= 1'b0;
      b_load      <= 1'b0;
      op          <= 2'b00;
      alu_req     <= 1'b0;
      result_show <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      gap         <= gap_nx;
      del_pend    <= del_pend_nx;
      sr_data     <= sr_data_nx;
      sr_shren    <= sr_shren_nx;
      sr_del      <= sr_del_nx;
      dig_cnt     <= dig_cnt_nx;
      a_load      <= a_load_nx;
      a_from_res  <= a_from_res_nx;
      b_load      <= b_load_nx;
      op          <= op_nx;
      alu_req     <= alu_req_nx;
      result_show <= result_show_nx;
      err         <= err_nx;
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: pulse outputs are checked against a timestamped event scoreboard.
module tb_calc_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic [7:0] sr_data;
  logic       sr_shren, sr_del;
  logic [3:0] dig_cnt;
  logic       a_load, a_from_res, b_load;
  logic [1:0] op;
  logic       alu_req, alu_done, alu_err, result_show, err;

  calc_entry_ctrl #(.MAX_DIGITS(6)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .sr_data(sr_data), .sr_shren(sr_shren), .sr_del(sr_del),
    .dig_cnt(dig_cnt), .a_load(a_load), .a_from_res(a_from_res), .b_load(b_load),
    .op(op), .alu_req(alu_req), .alu_done(alu_done), .alu_err(alu_err),
    .result_show(result_show), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] K_SHR = 4'd1, K_DEL = 4'd2, K_AL = 4'd3, K_BL = 4'd4, K_AR = 4'd5;

  typedef struct packed {
    logic [3:0]  kind;
    logic [7:0]  dat;
    logic [19:0] cyc;
  } ev_t;

  ev_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] cyc = '0;

  wire [22:0] outs = {key_ready, sr_data, sr_shren, sr_del, dig_cnt, a_load, a_from_res,
                      b_load, op, alu_req, result_show, err};
  localparam logic [22:0] RST_OUTS = 23'h400000;

  always @(posedge clk) cyc <= cyc + 20'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_ev(input logic [3:0] kind, input logic [7:0] dat, input int off);
    ev_t e;
    e.kind = kind;
    e.dat  = dat;
    e.cyc  = cyc + 20'(off);
    sb.push_back(e);
  endtask

  task automatic got(input logic [3:0] kind, input logic [7:0] dat);
    ev_t o, e;
    o.kind = kind;
    o.dat  = dat;
    o.cyc  = cyc;
    if (sb.size() == 0) chk("unexpected_pulse", o, 32'hFFFF_FFFF);
    else begin
      e = sb.pop_front();
      chk("pulse_event", o, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sr_shren || sr_del) chk("shren_del_excl", 32'(sr_shren & sr_del), 32'd0);
      if (sr_shren)   got(K_SHR, sr_data);
      if (sr_del)     got(K_DEL, 8'h00);
      if (a_load)     got(K_AL, 8'h00);
      if (b_load)     got(K_BL, 8'h00);
      if (a_from_res) got(K_AR, 8'h00);
    end
  end

  // Called at a falling edge; returns three falling edges later, when the next key may go in.
  task automatic press(input logic [7:0] c);
    chk("key_ready_before", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    chk("key_ready_busy", 32'(key_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press_dig(input logic [7:0] c);
    exp_ev(K_SHR, c, 1);
    press(c);
  endtask

  task automatic alu_pulse(input logic d, input logic e);
    alu_done = d;
    alu_err  = e;
    @(negedge clk);
    alu_done = 1'b0;
    alu_err  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; alu_done = 1'b0; alu_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs), 32'(RST_OUTS));
    rst = 1'b0;
    @(negedge clk);

    // Three spaced digits
    press_dig(8'h31); press_dig(8'h32); press_dig(8'h33);
    chk("dig_cnt_3", 32'(dig_cnt), 32'd3);
    exp_ev(K_DEL, 8'h00, 1); press(8'h43);
    chk("dig_cnt_clear", 32'(dig_cnt), 32'd0);

    // Seven digits: the seventh is dropped
    for (int i = 0; i < 7; i++) begin
      if (i < 6) exp_ev(K_SHR, 8'h30 + 8'(i), 1);
      press(8'h30 + 8'(i));
    end
    chk("dig_cnt_full", 32'(dig_cnt), 32'd6);
    exp_ev(K_DEL, 8'h00, 1); press(8'h43);

    // 5 + 7 =, done after 4 cycles
    press_dig(8'h35);
    exp_ev(K_AL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h2B);
    chk("op_add", 32'(op), 32'd0);
    chk("dig_cnt_after_op", 32'(dig_cnt), 32'd0);
    press_dig(8'h37);
    exp_ev(K_BL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h3D);
    chk("calc_key_ready", 32'(key_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("alu_req_held", 32'(alu_req), 32'd1);
      @(negedge clk);
    end
    alu_pulse(1'b1, 1'b0);
    chk("alu_req_drop", 32'(alu_req), 32'd0);
    chk("result_show", 32'(result_show), 32'd1);

    // Digit from RESULT, then 8 / 0 = with done and err together
    press_dig(8'h38);
    chk("result_show_off", 32'(result_show), 32'd0);
    chk("dig_cnt_from_result", 32'(dig_cnt), 32'd1);
    exp_ev(K_AL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h2F);
    chk("op_div", 32'(op), 32'd3);
    press_dig(8'h30);
    exp_ev(K_BL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h3D);
    @(negedge clk);
    alu_pulse(1'b1, 1'b1);
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_result", 32'(result_show), 32'd0);
    press(8'h33);
    chk("err_dig_dropped", 32'(dig_cnt), 32'd0);
    exp_ev(K_DEL, 8'h00, 1); press(8'h43);
    chk("err_cleared", 32'(err), 32'd0);

    // Operator from RESULT, then operator replacement in ENTER_B
    press_dig(8'h32);
    exp_ev(K_AL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h2A);
    press_dig(8'h33);
    exp_ev(K_BL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h3D);
    alu_pulse(1'b1, 1'b0);
    exp_ev(K_AR, 8'h00, 1); press(8'h2D);
    chk("op_from_result", 32'(op), 32'd1);
    chk("result_show_op", 32'(result_show), 32'd0);
    press(8'h2A);
    chk("op_replaced", 32'(op), 32'd2);
    press_dig(8'h34);
    press(8'h2F);
    chk("op_kept", 32'(op), 32'd2);
    exp_ev(K_DEL, 8'h00, 1); press(8'h43);

    // Back-to-back strobes: only the first is taken
    exp_ev(K_SHR, 8'h39, 1);
    key_valid = 1'b1; key_code = 8'h39;
    @(negedge clk);
    key_code = 8'h36;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b_dig_cnt", 32'(dig_cnt), 32'd1);

    // Async reset mid-CALC
    exp_ev(K_AL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h2B);
    press_dig(8'h32);
    exp_ev(K_BL, 8'h00, 1); exp_ev(K_DEL, 8'h00, 2); press(8'h3D);
    chk("req_before_rst", 32'(alu_req), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(alu_req), 32'd0);
    chk("rst_async_outs", 32'(outs), 32'(RST_OUTS));
    @(negedge clk);
    rst = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Keypad-entry sequencer for the calculator datapath. It accepts decoded key strobes and drives the 6-digit entry shift register through shift-enable and delete pulses. It tracks the operand A / operator / operand B entry flow, tells the operand registers when to capture the shift-register contents, and runs a req/done handshake with the arithmetic unit. It sits between the keypad decoder and the shift register / ALU.

## Interface
- MAX_DIGITS, 6: digits accepted per operand; further digit keys are dropped.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  key strobe; accepted only when key_ready is high.
- key_code  in  8  ASCII key:
  - 0x30–0x39 digits.
  - 0x2B '+', 0x2D '-', 0x2A '*', 0x2F '/' operators.
  - 0x3D '='.
  - 0x43 'C' clear.
  - Any other code: accepted, no effect.
- key_ready  out  1  controller can accept a key this cycle.
- sr_data  out  8  digit byte presented to the shift register; held until next digit.
- sr_shren  out  1  one-cycle shift pulse.
- sr_del  out  1  one-cycle clear pulse to the shift register.
- dig_cnt  out  4  digits in current operand, 0..MAX_DIGITS.
- a_load  out  1  one-cycle pulse: capture shift-register contents as operand A.
- a_from_res  out  1  one-cycle pulse: copy previous result into operand A.
- b_load  out  1  one-cycle pulse: capture shift-register contents as operand B.
- op  out  2  latched operator: 00 add, 01 sub, 10 mul, 11 div.
- alu_req  out  1  held high while the calculation is pending.
- alu_done  in  1  ALU completion pulse.
- alu_err  in  1  ALU error pulse (e.g. divide by zero, overflow).
- result_show  out  1  display should show the ALU result.
- err  out  1  error latched.

## Operation
- States: ENTER_A, ENTER_B, CALC, RESULT, ERROR.
- Reset state is ENTER_A; all outputs are 0 except key_ready = 1.
- Accepted key = key_valid && key_ready, sampled at the rising edge T. All responses are registered.
- Digit key in ENTER_A or ENTER_B:
  - dig_cnt < MAX_DIGITS: sr_data = key_code and sr_shren = 1 at T+1; dig_cnt increments.
  - dig_cnt = MAX_DIGITS: key dropped; no pulse, no count change.
- Operator key in ENTER_A:
  - dig_cnt > 0: op latched; a_load at T+1; sr_del at T+2; dig_cnt = 0; go to ENTER_B.
  - dig_cnt = 0: ignored.
- Operator key in ENTER_B:
  - dig_cnt = 0: op is replaced.
  - dig_cnt > 0: ignored.
- '=' in ENTER_B:
  - dig_cnt > 0: b_load at T+1; sr_del at T+2; dig_cnt = 0; alu_req rises at T+1; go to CALC.
  - dig_cnt = 0: ignored.
- '=' in ENTER_A, RESULT or ERROR: ignored.
- CALC: key_ready = 0; alu_req stays high until alu_done or alu_err is sampled high.
  - alu_done: alu_req drops next cycle; go to RESULT; result_show = 1.
  - alu_err: go to ERROR; err = 1.
  - alu_done and alu_err in the same cycle: error wins.
- RESULT:
  - Digit key: result_show = 0; shift the digit as in ENTER_A (dig_cnt = 1); go to ENTER_A.
  - Operator key: a_from_res at T+1; op latched; result_show = 0; go to ENTER_B.
- 'C' in ENTER_A, ENTER_B, RESULT or ERROR:
  - sr_del at T+1.
  - dig_cnt, op, err and result_show are cleared.
  - Go to ENTER_A.
- ERROR: only 'C' has effect; all other keys are accepted and dropped.
- rst in any state (including mid-CALC): every output returns asynchronously to its reset value; the state goes to ENTER_A.

## Timing
- key_ready is low at T+1 and T+2 after every accepted key, so the minimum key spacing is 3 cycles.
  - This guarantees sr_shren / sr_del are single-cycle high with at least 1 low cycle between pulses, because the shift register is edge-triggered on them.
- key_ready is also low for the whole of CALC.
- A key_valid seen while key_ready is low is dropped with no side effect.
- Latency, key to shift pulse: 1 cycle.
- Latency, operator or '=' to load pulse: 1 cycle; to delete pulse: 2 cycles.
- sr_data changes only in the cycle sr_shren rises and is stable while sr_shren is high.
- Never assert sr_shren and sr_del in the same cycle.

## Test plan
- Reset, then keys '1','2','3' spaced 3 cycles apart:
  - three sr_shren pulses with sr_data 0x31, 0x32, 0x33.
  - dig_cnt = 3.
- Seven digit keys:
  - six sr_shren pulses, then dig_cnt = 6.
  - seventh key produces no pulse.
- '5', '+', '7', '=', then alu_done after 4 cycles:
  - a_load, then sr_del one cycle later.
  - op = 00.
  - b_load then sr_del.
  - alu_req high until alu_done.
  - result_show = 1 and state RESULT.
- '8', '/', '0', '=', then alu_done and alu_err together:
  - err = 1.
  - '3' produces no pulse.
  - 'C' produces sr_del and err = 0.
- Back-to-back key_valid on consecutive cycles: only the first is accepted; exactly one sr_shren.
- rst asserted while alu_req is high:
  - alu_req falls without waiting for a clock edge.
  - all outputs go to their reset values; key_ready = 1.
